// File: rtl/iter_mul_unit.sv
// Iterative unsigned WIDTHxWIDTH shift-add multiplier with a fixed-latency
// single-cycle register-file write strobe at completion.
module iter_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [4:0]       rd_out,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_hi_q;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   result_q;

  // Accumulator value after the current RUN step; also feeds the final half select.
  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      op_hi_q  <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_hi_q  <= op_hi;
            rd_q     <= rd_in;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // The last step's sum is final, so capture the selected half here
          // and hold it steady through DONE and the following IDLE.
          if (cnt_q == LAST_CNT) begin
            result_q <= op_hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign wr_en  = (state_q == S_DONE) && (rd_q != 5'd0);
  assign rd_out = rd_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed self-checking bench for iter_mul_unit: latency, product halves,
// x0 write suppression, ignored starts, reset abort and back-to-back issue.
module tb_iter_mul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_hi = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd_in = '0;
  logic        ready, busy, done, wr_en;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int excl_err = 0;
  bit mon_en = 1'b0;

  iter_mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_hi(op_hi), .a(a), .b(b),
    .rd_in(rd_in), .ready(ready), .busy(busy), .done(done), .wr_en(wr_en),
    .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  // ready/busy/done must be one-hot every cycle after the first reset
  always @(negedge clk)
    if (mon_en && ((int'(ready) + int'(busy) + int'(done)) != 1)) excl_err++;

  // Issues one op and observes it until the cycle after done (bounded).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic thi, input logic [4:0] trd,
                        output int lat, output int busy_cnt, output int wr_cnt,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output logic rdy_after);
    lat = -1; busy_cnt = 0; wr_cnt = 0; res = '0; rdo = '0; rdy_after = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; op_hi = thi; rd_in = trd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (lat >= 0) begin
        rdy_after = ready;
        break;
      end
      if (busy) busy_cnt++;
      if (wr_en) wr_cnt++;
      if (done) begin
        lat = n; res = result; rdo = rd_out;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    checks++;
    if ({ready, busy, done, wr_en} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b expected=1000", {ready, busy, done, wr_en});
    end
    checks++;
    if (rd_out !== 5'd0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_data rd_out=%0d result=%h expected 0/0", rd_out, result);
    end
  endtask

  task automatic test_basic();
    int lat, bc, wc; logic [31:0] res; logic [4:0] rdo; logic ra;
    run_op(32'd3, 32'd5, 1'b0, 5'd7, lat, bc, wc, res, rdo, ra);
    checks++;
    if (lat != 33) begin failures++; $display("FAIL basic_latency got=%0d expected=33", lat); end
    checks++;
    if (bc != 32) begin failures++; $display("FAIL basic_busy_cycles got=%0d expected=32", bc); end
    checks++;
    if (wc != 1) begin failures++; $display("FAIL basic_wr_pulses got=%0d expected=1", wc); end
    checks++;
    if (res !== 32'h0000000F) begin failures++; $display("FAIL basic_result got=%h expected=0000000f", res); end
    checks++;
    if (rdo !== 5'd7) begin failures++; $display("FAIL basic_rd_out got=%0d expected=7", rdo); end
    checks++;
    if (ra !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b expected=1", ra); end
    repeat (5) @(negedge clk);
    checks++;
    if (result !== 32'h0000000F || rd_out !== 5'd7) begin
      failures++;
      $display("FAIL basic_hold result=%h rd_out=%0d expected 0000000f/7", result, rd_out);
    end
  endtask

  task automatic test_halves();
    int lat, bc, wc; logic [31:0] res; logic [4:0] rdo; logic ra;
    // 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd1, lat, bc, wc, res, rdo, ra);
    checks++;
    if (res !== 32'hFFFFFFFE || lat != 33) begin
      failures++;
      $display("FAIL max_mulhu got=%h lat=%0d expected fffffffe/33", res, lat);
    end
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd1, lat, bc, wc, res, rdo, ra);
    checks++;
    if (res !== 32'h00000001 || wc != 1) begin
      failures++;
      $display("FAIL max_mul got=%h wr=%0d expected 00000001/1", res, wc);
    end
    // 0x80000000 * 2 = 0x1_00000000: carry lands exactly in the high half
    run_op(32'h80000000, 32'd2, 1'b1, 5'd9, lat, bc, wc, res, rdo, ra);
    checks++;
    if (res !== 32'h00000001) begin failures++; $display("FAIL carry_mulhu got=%h expected=00000001", res); end
    run_op(32'h80000000, 32'd2, 1'b0, 5'd9, lat, bc, wc, res, rdo, ra);
    checks++;
    if (res !== 32'h00000000) begin failures++; $display("FAIL carry_mul got=%h expected=00000000", res); end
    run_op(32'hDEADBEEF, 32'd1, 1'b0, 5'd31, lat, bc, wc, res, rdo, ra);
    checks++;
    if (res !== 32'hDEADBEEF || rdo !== 5'd31) begin
      failures++;
      $display("FAIL identity got=%h rd=%0d expected deadbeef/31", res, rdo);
    end
  endtask

  task automatic test_zero_x0();
    int lat, bc, wc; logic [31:0] res; logic [4:0] rdo; logic ra;
    run_op(32'h12345678, 32'd0, 1'b0, 5'd0, lat, bc, wc, res, rdo, ra);
    checks++;
    if (lat != 33) begin failures++; $display("FAIL zero_latency got=%0d expected=33", lat); end
    checks++;
    if (res !== 32'd0) begin failures++; $display("FAIL zero_result got=%h expected=00000000", res); end
    checks++;
    if (wc != 0) begin failures++; $display("FAIL x0_wr_en got=%0d expected=0", wc); end
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0;
    logic [31:0] res = '0;
    logic [4:0] rdo = '0;
    @(negedge clk);
    a = 32'd2; b = 32'd2; op_hi = 1'b0; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      if (n == 10) begin
        a = 32'd9; b = 32'd9; op_hi = 1'b1; rd_in = 5'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++; res = result; rdo = rd_out;
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL ignore_done_count got=%0d expected=1", done_cnt); end
    checks++;
    if (res !== 32'd4 || rdo !== 5'd3) begin
      failures++;
      $display("FAIL ignore_result got=%h rd=%0d expected 00000004/3", res, rdo);
    end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL ignore_idle ready=%b expected=1", ready); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clk);
    a = 32'd3; b = 32'd5; op_hi = 1'b0; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b expected=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || result !== 32'd0 || rd_out !== 5'd0) begin
      failures++;
      $display("FAIL abort_state flags=%b result=%h rd=%0d expected 100/0/0",
               {ready, busy, done}, result, rd_out);
    end
    for (int n = 0; n < 40; n++) begin
      if (done || wr_en) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL abort_no_done got=%0d expected=0", pulses); end
    // reset dominates a simultaneous start
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_vs_start ready=%b busy=%b expected 1/0", ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int ready_between = 0;
    int bad_res = 0;
    bit idle_seen = 1'b0;
    @(negedge clk);
    a = 32'd6; b = 32'd7; op_hi = 1'b0; rd_in = 5'd4; start = 1'b1;
    for (int n = 1; n <= 105; n++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(n);
        if (result !== 32'h2A) bad_res++;
      end
      if (ready && n > 33 && n < 67) ready_between++;
    end
    start = 1'b0;
    checks++;
    if (done_at.size() != 3) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d expected=3", done_at.size());
    end else begin
      checks++;
      if (done_at[0] != 33 || done_at[1] != 67 || done_at[2] != 101) begin
        failures++;
        $display("FAIL b2b_done_times got=%0d,%0d,%0d expected=33,67,101",
                 done_at[0], done_at[1], done_at[2]);
      end
    end
    checks++;
    if (bad_res != 0) begin failures++; $display("FAIL b2b_result bad=%0d expected=0", bad_res); end
    checks++;
    if (ready_between != 1) begin
      failures++;
      $display("FAIL b2b_ready_gap got=%0d expected=1", ready_between);
    end
    for (int n = 0; n < 40 && !idle_seen; n++) begin
      @(negedge clk);
      if (ready) idle_seen = 1'b1;
    end
    checks++;
    if (!idle_seen) begin failures++; $display("FAIL b2b_drain ready never returned"); end
  endtask

  task automatic test_exclusive();
    checks++;
    if (excl_err != 0) begin
      failures++;
      $display("FAIL one_hot_flags violations=%0d expected=0", excl_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halves();
    test_zero_x0();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_mul_unit.md
# iter_mul_unit

Multi-cycle unsigned 32x32 shift-add multiplier feeding the destination register-file write port. It accepts operands and a destination index from decode, iterates one multiplier bit per clock, then issues a single-cycle write strobe whose data/strobe pair drives a register's data input and load-select input directly. Fixed latency keeps stall logic in the control path trivial.

## Interface
- WIDTH, 32, operand and result width in bits (the design is verified only at 32)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; one clock, synchronous, active-high
- start  input  1  request a multiply; honoured only when ready=1
- op_hi  input  1  0: return low WIDTH bits of product (MUL); 1: return high WIDTH bits (MULHU)
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- rd_in  input  5  destination register index
- ready  output  1  unit idle, start will be accepted
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse: result valid
- wr_en  output  1  one-cycle write strobe to register file (load-select of target register)
- rd_out  output  5  latched destination index
- result  output  WIDTH  selected product half

## Operation
- States: IDLE, RUN, DONE. All outputs decoded from registered state/datapath, no combinational path from inputs to outputs.
- IDLE: ready=1. On edge with start=1: latch a, b, op_hi, rd_in; clear 2*WIDTH-bit accumulator; count<=0; go RUN. start=0: stay.
- RUN: busy=1. Each edge: if multiplier LSB=1, add shifted multiplicand into accumulator; shift multiplier right, multiplicand left; count<=count+1. On the edge where count reaches WIDTH-1 (WIDTH-th RUN edge) go DONE.
- DONE: done=1; wr_en=1 only if rd_out!=0 (x0 is never written). result = acc[WIDTH-1:0] if op_hi=0 else acc[2*WIDTH-1:WIDTH]. Next edge unconditionally to IDLE.
- Arithmetic: full unsigned 2*WIDTH-bit product, no overflow, no truncation until half select. Zero operands still take full latency (no early exit).
- start while busy or in DONE: ignored, not queued; latched operands unaffected by input changes after acceptance.
- result and rd_out hold their last values through IDLE until the next accepted start; only done/wr_en are pulses.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, wr_en=0, rd_out=0, result=0, accumulator/count=0.
- Start accepted at edge k -> busy high cycles k+1..k+WIDTH -> done/wr_en high exactly one cycle after edge k+WIDTH -> ready high after edge k+WIDTH+1. Latency start-edge to done = WIDTH+1 clocks (33).
- Back-to-back: start asserted in the first IDLE cycle after DONE is accepted; minimum issue interval WIDTH+2 clocks.
- ready, busy, done mutually exclusive, exactly one high every cycle after reset.
- rst=1 at any edge (incl. mid-RUN or in DONE): abort, all outputs to reset values next cycle, no done/wr_en pulse emitted for aborted op; rst dominates simultaneous start.

## Test plan
- Reset then a=3, b=5, op_hi=0, rd_in=7, start one cycle -> busy 32 cycles, done=wr_en=1 for one cycle 33 clocks after start edge, result=0x0000000F, rd_out=7.
- a=b=0xFFFFFFFF, op_hi=1, rd_in=1 -> result=0xFFFFFFFE; repeat op_hi=0 -> result=0x00000001.
- a=0x12345678, b=0, rd_in=0 -> done pulses after 33 clocks, result=0, wr_en stays 0 throughout.
- Start op (a=2,b=2), pulse start again at cycle 10 with a=9,b=9 -> single done, result=4; input change after acceptance has no effect.
- Start op, assert rst at RUN cycle 15 -> next cycle ready=1, busy=0, result=0, rd_out=0; no done/wr_en for 40 cycles.
- Start asserted continuously with a=6,b=7 -> done pulses every 34 clocks, result=0x2A each, ready high exactly one cycle between ops.
